// File: rtl/fp16_div_pkg.sv
// rtl/fp16_div_pkg.sv - shared types and constants for the fp16 iterative divider
package fp16_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_ROUND
    } div_state_t;

    localparam logic signed [6:0] FP16_BIAS = 7'sd15;
    localparam logic [15:0]       FP16_QNAN = 16'h7E00;
    localparam logic [14:0]       FP16_INF  = 15'h7C00;
    localparam logic [14:0]       FP16_MAXF = 15'h7BFF;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    localparam int DIV_ITERS = 14;

endpackage

// File: rtl/fp16_div_unpack.sv
// rtl/fp16_div_unpack.sv - fp16 operand classification and significand unpack (FP_DIV_DENORM_EN)
module fp16_div_unpack
    import fp16_div_pkg::*;
(
    input  logic [15:0]       x,
    output logic              sign,
    output logic              zero,
    output logic              inf,
    output logic              nan,
    output logic [10:0]       sig,
    output logic signed [6:0] exp
);
    logic [4:0] ex;
    logic [9:0] frac;

    assign ex   = x[14:10];
    assign frac = x[9:0];
    assign sign = x[15];
    assign nan  = (&ex) && (|frac);
    assign inf  = (&ex) && !(|frac);

`ifdef FP_DIV_DENORM_EN
    logic [3:0] lz;

    assign zero = (ex == 5'd0) && (frac == 10'd0);

    // Highest set bit wins: shift needed to move it to the hidden-bit position.
    always_comb begin
        lz = 4'd0;
        for (int i = 0; i <= 9; i++) begin
            if (frac[i]) lz = 4'(10 - i);
        end
    end

    always_comb begin
        if (ex == 5'd0) begin
            sig = {1'b0, frac} << lz;
            exp = 7'sd1 - signed'({3'b000, lz});
        end else begin
            sig = {1'b1, frac};
            exp = signed'({2'b00, ex});
        end
    end
`else
    assign zero = (ex == 5'd0);
    assign sig  = {1'b1, frac};
    assign exp  = signed'({2'b00, ex});
`endif

endmodule

// File: rtl/fp16_iter_divider.sv
// rtl/fp16_iter_divider.sv - iterative restoring fp16 divider, fixed 16-cycle latency (FP_DIV_DENORM_EN)
module fp16_iter_divider
    import fp16_div_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        e,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  rm,
    output logic [15:0] q,
    output logic        busy,
    output logic        ready
);
    div_state_t        state;
    logic [3:0]        cnt;
    logic [15:0]       a_r, b_r;
    logic [1:0]        rm_r;
    logic              sign_r;
    logic signed [6:0] exp_r;
    logic [10:0]       mb;
    logic [11:0]       rem;
    logic [13:0]       qt;
    logic              spec_r;
    logic [15:0]       spec_val;

    logic              sa, za, ia, na, sb, zb, ib, nb;
    logic [10:0]       sig_a, sig_b;
    logic signed [6:0] ea, eb;

    fp16_div_unpack u_unpack_a (.x(a_r), .sign(sa), .zero(za), .inf(ia), .nan(na), .sig(sig_a), .exp(ea));
    fp16_div_unpack u_unpack_b (.x(b_r), .sign(sb), .zero(zb), .inf(ib), .nan(nb), .sig(sig_b), .exp(eb));

    logic        spec_f;
    logic [15:0] spec_v;

    always_comb begin
        spec_f = 1'b1;
        spec_v = FP16_QNAN;
        if (na || nb || (za && zb) || (ia && ib)) spec_v = FP16_QNAN;
        else if (zb || ia)                        spec_v = {sa ^ sb, FP16_INF};
        else if (za || ib)                        spec_v = {sa ^ sb, 15'h0000};
        else                                      spec_f = 1'b0;
    end

    logic        ge;
    logic [11:0] rem_sub;

    assign ge      = rem >= {1'b0, mb};
    assign rem_sub = ge ? rem - {1'b0, mb} : rem;

    logic [13:0]       norm;
    logic signed [6:0] exp_n;
    logic [12:0]       shifted;
    logic              lost, g, st, lsb, inc, away;
    logic [4:0]        exp_f;
    logic [14:0]       mag;
    logic [15:0]       res;

    always_comb begin
        norm    = qt[13] ? qt : {qt[12:0], 1'b0};
        exp_n   = qt[13] ? exp_r : exp_r - 7'sd1;
        shifted = norm[12:0];
        lost    = 1'b0;
`ifdef FP_DIV_DENORM_EN
        // Underflow: denormalise, everything shifted past the guard feeds sticky.
        if (exp_n <= 7'sd0) begin
            logic [3:0] sh;
            sh      = (exp_n < -7'sd13) ? 4'd15 : 4'(7'sd1 - exp_n);
            shifted = 13'(norm >> sh);
            lost    = |(norm & ~(14'h3FFF << sh));
        end
`endif
        g   = shifted[2];
        st  = (|shifted[1:0]) | lost | (|rem);
        lsb = shifted[3];
        case (rm_r)
            RM_RNE:  inc = g & (st | lsb);
            RM_RDN:  inc = sign_r & (g | st);
            RM_RUP:  inc = ~sign_r & (g | st);
            default: inc = 1'b0;
        endcase
        away  = (rm_r == RM_RNE) || ((rm_r == RM_RDN) && sign_r) || ((rm_r == RM_RUP) && !sign_r);
        exp_f = (exp_n <= 7'sd0) ? 5'd0 : exp_n[4:0];
        // Mantissa carry ripples straight into the exponent field.
        mag   = {exp_f, shifted[12:3]} + {14'd0, inc};
        if (spec_r)                  res = spec_val;
        else if (exp_n >= 7'sd31)    res = {sign_r, away ? FP16_INF : FP16_MAXF};
`ifndef FP_DIV_DENORM_EN
        else if (exp_n <= 7'sd0)     res = {sign_r, 15'h0000};
`endif
        else                         res = {sign_r, mag};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            a_r      <= 16'h0000;
            b_r      <= 16'h0000;
            rm_r     <= RM_RNE;
            sign_r   <= 1'b0;
            exp_r    <= 7'sd0;
            mb       <= 11'd0;
            rem      <= 12'd0;
            qt       <= 14'd0;
            spec_r   <= 1'b0;
            spec_val <= 16'h0000;
            q        <= 16'h0000;
            busy     <= 1'b0;
            ready    <= 1'b0;
        end else if (e) begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        rm_r  <= rm;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sign_r   <= sa ^ sb;
                    exp_r    <= ea - eb + FP16_BIAS;
                    rem      <= {1'b0, sig_a};
                    mb       <= sig_b;
                    qt       <= 14'd0;
                    spec_r   <= spec_f;
                    spec_val <= spec_v;
                    cnt      <= 4'(DIV_ITERS - 1);
                    state    <= S_DIV;
                end
                S_DIV: begin
                    qt  <= {qt[12:0], ge};
                    rem <= {rem_sub[10:0], 1'b0};
                    if (cnt == 4'd0) state <= S_ROUND;
                    else             cnt   <= cnt - 4'd1;
                end
                S_ROUND: begin
                    q     <= res;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_iter_divider.sv
// tb/tb_fp16_iter_divider.sv - directed vector bench for fp16_iter_divider (FP_DIV_DENORM_EN aware)
module tb_fp16_iter_divider;

    logic        clk = 1'b0;
    logic        clrn;
    logic        e;
    logic        start;
    logic [15:0] a, b;
    logic [1:0]  rm;
    logic [15:0] q;
    logic        busy, ready;

    int checks = 0;
    int errors = 0;

    fp16_iter_divider dut (
        .clk(clk), .clrn(clrn), .e(e), .start(start), .a(a), .b(b), .rm(rm),
        .q(q), .busy(busy), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  rm;
        logic [15:0] want;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, want);
        end
    endtask

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_in, input logic [1:0] trm);
        a = ta; b = tb_in; rm = trm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n, extra;
        logic [15:0] held;

        vecs[0]  = '{16'h3C00, 16'h3C00, 2'b00, 16'h3C00};
        vecs[1]  = '{16'h4600, 16'h4000, 2'b00, 16'h4200};
        vecs[2]  = '{16'h3C00, 16'h4200, 2'b00, 16'h3555};
        vecs[3]  = '{16'h3C00, 16'h4200, 2'b11, 16'h3555};
        vecs[4]  = '{16'h3C00, 16'h4200, 2'b10, 16'h3556};
        vecs[5]  = '{16'hBC00, 16'h4200, 2'b01, 16'hB556};
        vecs[6]  = '{16'h3C00, 16'h0000, 2'b00, 16'h7C00};
        vecs[7]  = '{16'h0000, 16'h0000, 2'b00, 16'h7E00};
        vecs[8]  = '{16'h7C00, 16'h4000, 2'b00, 16'h7C00};
        vecs[9]  = '{16'hC000, 16'h7C00, 2'b00, 16'h8000};
        vecs[10] = '{16'h7C01, 16'h3C00, 2'b00, 16'h7E00};
        vecs[11] = '{16'h7BFF, 16'h3800, 2'b00, 16'h7C00};
        vecs[12] = '{16'h7BFF, 16'h3800, 2'b11, 16'h7BFF};
        vecs[13] = '{16'h7BFF, 16'h3800, 2'b10, 16'h7C00};
        vecs[14] = '{16'h7BFF, 16'h3800, 2'b01, 16'h7BFF};
        vecs[15] = '{16'hBC00, 16'h3C00, 2'b00, 16'hBC00};
        vecs[16] = '{16'h7C00, 16'h7C00, 2'b00, 16'h7E00};
`ifdef FP_DIV_DENORM_EN
        vecs[17] = '{16'h0001, 16'h3C00, 2'b00, 16'h0001};
        vecs[18] = '{16'h0400, 16'h4000, 2'b00, 16'h0200};
`else
        vecs[17] = '{16'h0001, 16'h3C00, 2'b00, 16'h0000};
        vecs[18] = '{16'h0400, 16'h4000, 2'b00, 16'h0000};
`endif

        clrn = 1'b0; e = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; rm = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset q", 32'(q), 32'h0000);
        check("reset busy", 32'(busy), 32'h0);
        check("reset ready", 32'(ready), 32'h0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].rm);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'h1);
            wait_ready(n);
            check($sformatf("vec%0d latency", i), 32'(n), 32'd16);
            check($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].want));
            check($sformatf("vec%0d busy_end", i), 32'(busy), 32'h0);
            @(posedge clk); #1;
            check($sformatf("vec%0d ready_pulse", i), 32'(ready), 32'h0);
        end

        // back-to-back: second request issued in the ready cycle
        issue(16'h3C00, 16'h3C00, 2'b00);
        wait_ready(n);
        check("b2b first q", 32'(q), 32'h3C00);
        issue(16'h4600, 16'h4000, 2'b00);
        wait_ready(n);
        check("b2b latency", 32'(n), 32'd16);
        check("b2b second q", 32'(q), 32'h4200);
        @(posedge clk); #1;

        // start while busy is ignored
        issue(16'h4000, 16'h3C00, 2'b00);
        repeat (4) begin @(posedge clk); #1; end
        a = 16'h3C00; b = 16'h4200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(n);
        check("busy start latency", 32'(n + 5), 32'd16);
        check("busy start q", 32'(q), 32'h4000);
        @(posedge clk); #1;

        // asynchronous abort during DIV
        issue(16'h4600, 16'h4000, 2'b00);
        repeat (5) begin @(posedge clk); #1; end
        clrn = 1'b0;
        #1;
        check("abort q", 32'(q), 32'h0000);
        check("abort busy", 32'(busy), 32'h0);
        check("abort ready", 32'(ready), 32'h0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk); #1;
        issue(16'h4000, 16'h3C00, 2'b00);
        wait_ready(n);
        check("post abort latency", 32'(n), 32'd16);
        check("post abort q", 32'(q), 32'h4000);
        @(posedge clk); #1;

        // enable freeze mid-operation and during ready
        issue(16'h3C00, 16'h4200, 2'b10);
        repeat (3) begin @(posedge clk); #1; end
        e = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("freeze busy", 32'(busy), 32'h1);
        e = 1'b1;
        wait_ready(extra);
        check("freeze latency", 32'(3 + 5 + extra), 32'd21);
        check("freeze q", 32'(q), 32'h3556);
        held = q;
        e = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("frozen ready", 32'(ready), 32'h1);
        check("frozen q", 32'(q), 32'(held));
        e = 1'b1;
        @(posedge clk); #1;
        check("thawed ready", 32'(ready), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
